// File: rtl/cs_pkg.sv
// Shared definitions for the CS stream driver/checker.
// X_W/Y_W : sample and result widths of the CS filter
// WIN     : CS window length (samples per result)
// cs_state_e : driver/checker run state
// n_out() : number of results CS produces for a stream of n_pat samples
package cs_pkg;
  localparam int X_W = 8;
  localparam int Y_W = 10;
  localparam int WIN = 9;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} cs_state_e;

  function automatic int n_out(input int n_pat);
    return n_pat - (WIN - 1);
  endfunction
endpackage

// File: rtl/cs_err_tally.sv
// Mismatch bookkeeping for the CS checker.
// clk, reset      : clock, sync active-high reset
// clear           : start of a new run, same effect as reset
// cmp_en/mismatch : a compare happens this edge / it failed
// idx             : pattern index of the current compare
// fin             : final compare edge, latches pass
// err_cnt         : saturating mismatch count
// first_err_idx   : index of first mismatch, all-ones if none
// pass            : 1 iff no mismatch, valid once fin has been seen
module cs_err_tally #(
  parameter int ADDR_W = 15,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              cmp_en,
  input  logic              mismatch,
  input  logic [ADDR_W-1:0] idx,
  input  logic              fin,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic              pass
);
  logic             hit;
  logic [ERR_W-1:0] err_nxt;

  assign hit     = cmp_en && mismatch;
  assign err_nxt = (hit && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      err_cnt       <= '0;
      first_err_idx <= '1;
      pass          <= 1'b0;
    end else begin
      err_cnt <= err_nxt;
      if (hit && first_err_idx == '1) first_err_idx <= idx;
      // pass must include the compare landing on this same edge
      if (fin) pass <= (err_nxt == '0);
    end
  end
endmodule

// File: rtl/cs_stream_driver_checker.sv
// Source/sink harness for the CS median-approximation filter: streams
// N_PAT samples from a sample memory into CS and checks every CS result
// against a golden memory. Both memories are sync-read, 1-cycle latency.
// Ports:
//   clk, reset          : clock, sync active-high reset
//   start               : one-cycle pulse, starts a run from IDLE/DONE
//   x_addr / x_rdata    : sample memory read port
//   X                   : registered sample to CS
//   Y                   : CS result
//   gold_addr/gold_rdata: golden memory read port
//   busy, done, pass    : run status (pass valid while done)
//   err_cnt             : saturating mismatch count
//   first_err_idx       : first failing pattern index, all-ones if none
// Timing reference: edge E0 is the edge that accepts start; cyc holds k-1
// during the cycle ending at edge Ek, and every address/window is derived
// from it.
module cs_stream_driver_checker
  import cs_pkg::*;
#(
  parameter int N_PAT  = 2000,
  parameter int LAT    = 9,
  parameter int ADDR_W = 15,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] x_addr,
  input  logic [X_W-1:0]    x_rdata,
  output logic [X_W-1:0]    X,
  input  logic [Y_W-1:0]    Y,
  output logic [ADDR_W-1:0] gold_addr,
  input  logic [Y_W-1:0]    gold_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_idx
);
  localparam int N_OUT = n_out(N_PAT);
  localparam int CW    = ADDR_W + 1;

  // cyc thresholds (value seen at the edge in question)
  localparam logic [CW-1:0] CY_XHOLD = CW'(N_PAT - 1);         // last x_addr step
  localparam logic [CW-1:0] CY_DRAIN = CW'(N_PAT);             // edge E(N_PAT+1)
  localparam logic [CW-1:0] CY_G0    = CW'(LAT);               // gold_addr=0 loaded
  localparam logic [CW-1:0] CY_GLAST = CW'(LAT + N_OUT - 1);   // last gold_addr load
  localparam logic [CW-1:0] CY_CMP0  = CW'(LAT + 2);           // compare j=0
  localparam logic [CW-1:0] CY_LAST  = CW'(LAT + N_OUT + 1);   // compare j=N_OUT-1

  cs_state_e         state;
  logic [CW-1:0]     cyc;
  logic              running, go, cmp_en, fin, mismatch;
  logic [ADDR_W-1:0] idx;

  assign running  = (state == RUN) || (state == DRAIN);
  assign go       = start && ((state == IDLE) || (state == DONE));
  assign cmp_en   = running && (cyc >= CY_CMP0) && (cyc <= CY_LAST);
  assign fin      = running && (cyc == CY_LAST);
  assign idx      = ADDR_W'(cyc - CY_CMP0);
  // case inequality so an X/Z on Y is treated as a failure in simulation
  assign mismatch = (Y !== gold_rdata);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cyc       <= '0;
      x_addr    <= '0;
      gold_addr <= '0;
      X         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            cyc       <= '0;
            x_addr    <= '0;
            gold_addr <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        RUN, DRAIN: begin
          cyc <= cyc + 1'b1;
          if (cyc < CY_XHOLD) x_addr <= ADDR_W'(cyc + 1'b1);
          // x_rdata first reflects x_addr=0 at E2; after the last address
          // the same word keeps coming back, so X holds the last sample
          if (cyc != '0) X <= x_rdata;
          if (cyc >= CY_G0 && cyc <= CY_GLAST) gold_addr <= ADDR_W'(cyc - CY_G0);
          if (cyc == CY_DRAIN) state <= DRAIN;
          if (cyc == CY_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  cs_err_tally #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) u_tally (
    .clk          (clk),
    .reset        (reset),
    .clear        (go),
    .cmp_en       (cmp_en),
    .mismatch     (mismatch),
    .idx          (idx),
    .fin          (fin),
    .err_cnt      (err_cnt),
    .first_err_idx(first_err_idx),
    .pass         (pass)
  );
endmodule

// File: tb/tb_cs_stream_driver_checker.sv
// Bench: a 16-sample instance for directed timing/error checks and a
// default 2000-sample instance for a long clean run. CS is modelled as a
// 9-deep shift register sampling X every edge with Y = 10-bit window sum.
module tb_cs_stream_driver_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start1, start2;
  int   total = 0, bad = 0;

  logic [14:0] xa1, ga1, fe1, xa2, ga2, fe2;
  logic [7:0]  xr1, X1, xr2, X2;
  logic [9:0]  Y1, gr1, Y2, gr2;
  logic        busy1, done1, pass1, busy2, done2, pass2;
  logic [15:0] ec1, ec2;

  logic [7:0] xm1 [16];
  logic [9:0] gm1 [8];
  logic [7:0] xm2 [2000];
  logic [9:0] gm2 [1992];
  logic [7:0] sr1 [9];
  logic [7:0] sr2 [9];
  logic [7:0] xq [$];

  cs_stream_driver_checker #(.N_PAT(16)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .x_addr(xa1), .x_rdata(xr1),
    .X(X1), .Y(Y1), .gold_addr(ga1), .gold_rdata(gr1), .busy(busy1),
    .done(done1), .pass(pass1), .err_cnt(ec1), .first_err_idx(fe1));

  cs_stream_driver_checker dut2 (
    .clk(clk), .reset(reset), .start(start2), .x_addr(xa2), .x_rdata(xr2),
    .X(X2), .Y(Y2), .gold_addr(ga2), .gold_rdata(gr2), .busy(busy2),
    .done(done2), .pass(pass2), .err_cnt(ec2), .first_err_idx(fe2));

  // memories, sync read
  always @(posedge clk) begin
    xr1 <= xm1[xa1[3:0]];
    gr1 <= gm1[ga1[2:0]];
    xr2 <= xm2[xa2];
    gr2 <= gm2[ga2];
  end

  // CS models
  always @(posedge clk) begin
    for (int i = 8; i > 0; i--) begin
      sr1[i] <= sr1[i-1];
      sr2[i] <= sr2[i-1];
    end
    sr1[0] <= X1;
    sr2[0] <= X2;
  end
  assign Y1 = 10'(sr1[0]) + 10'(sr1[1]) + 10'(sr1[2]) + 10'(sr1[3]) + 10'(sr1[4])
            + 10'(sr1[5]) + 10'(sr1[6]) + 10'(sr1[7]) + 10'(sr1[8]);
  assign Y2 = 10'(sr2[0]) + 10'(sr2[1]) + 10'(sr2[2]) + 10'(sr2[3]) + 10'(sr2[4])
            + 10'(sr2[5]) + 10'(sr2[6]) + 10'(sr2[7]) + 10'(sr2[8]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // pulse start1 across edge E0, pushing the expected X stream
  task automatic go1();
    xq.delete();
    for (int k = 0; k < 16; k++) xq.push_back(xm1[k]);
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
  endtask

  initial begin
    logic [9:0] s;
    for (int k = 0; k < 16; k++) xm1[k] = 8'(k);
    for (int j = 0; j < 8; j++) begin
      s = '0;
      for (int i = 0; i < 9; i++) s = s + 10'(xm1[j+i]);
      gm1[j] = s;
    end
    for (int k = 0; k < 2000; k++) xm2[k] = 8'(k * 37 + 11);
    for (int j = 0; j < 1992; j++) begin
      s = '0;
      for (int i = 0; i < 9; i++) s = s + 10'(xm2[j+i]);
      gm2[j] = s;
    end

    // reset
    reset = 1'b1; start1 = 1'b0; start2 = 1'b0;
    tick(2);
    reset = 1'b0;
    chk("rst_X", X1, 0);
    chk("rst_x_addr", xa1, 0);
    chk("rst_gold_addr", ga1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_err_cnt", ec1, 0);
    chk("rst_first_err", fe1, 15'h7fff);

    // clean run with X stream scoreboard
    go1();
    chk("run_busy", busy1, 1);
    chk("run_x_addr0", xa1, 0);
    for (int k = 1; k <= 19; k++) begin
      tick(1);
      if (k >= 2 && k <= 17) chk("x_stream", X1, xq.pop_front());
      if (k == 7) chk("x_at_e7", X1, 5);
      if (k == 11) chk("gold_addr_e11", ga1, 1);
      if (k == 17) chk("x_addr_hold", xa1, 15);
      if (k == 18) chk("done_before_e19", done1, 0);
    end
    chk("clean_done", done1, 1);
    chk("clean_busy", busy1, 0);
    chk("clean_pass", pass1, 1);
    chk("clean_err_cnt", ec1, 0);
    chk("clean_first_err", fe1, 15'h7fff);
    chk("x_held", X1, 15);
    chk("x_addr_end", xa1, 15);

    // mismatches at patterns 2 and 5, restart from DONE, stray starts
    gm1[2] = gm1[2] ^ 10'h1;
    gm1[5] = gm1[5] ^ 10'h1;
    go1();
    chk("restart_done_clr", done1, 0);
    chk("restart_err_clr", ec1, 0);
    for (int k = 1; k <= 19; k++) begin
      tick(1);
      if (k == 4 || k == 17) start1 = 1'b1;   // seen at E5 (RUN), E18 (DRAIN)
      if (k == 5 || k == 18) start1 = 1'b0;
      if (k == 13) chk("err_before_j2", ec1, 0);
      if (k == 14) chk("err_at_j2", ec1, 1);
      if (k == 14) chk("first_err_j2", fe1, 2);
      if (k == 16) chk("err_before_j5", ec1, 1);
      if (k == 17) chk("err_at_j5", ec1, 2);
      if (k == 18) chk("err_done_early", done1, 0);
    end
    chk("err_done", done1, 1);
    chk("err_busy", busy1, 0);
    chk("err_pass", pass1, 0);
    chk("err_cnt_final", ec1, 2);
    chk("err_first_final", fe1, 2);
    gm1[2] = gm1[2] ^ 10'h1;
    gm1[5] = gm1[5] ^ 10'h1;

    // reset mid-run, then a fresh clean run
    go1();
    tick(7);
    reset = 1'b1;
    tick(2);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_done", done1, 0);
    chk("mid_rst_X", X1, 0);
    chk("mid_rst_x_addr", xa1, 0);
    chk("mid_rst_gold_addr", ga1, 0);
    chk("mid_rst_err", ec1, 0);
    chk("mid_rst_first", fe1, 15'h7fff);
    reset = 1'b0;
    tick(1);
    go1();
    for (int k = 1; k <= 19; k++) begin
      tick(1);
      if (k >= 2 && k <= 17) chk("x_stream2", X1, xq.pop_front());
      if (k == 18) chk("rerun_done_early", done1, 0);
    end
    chk("rerun_done", done1, 1);
    chk("rerun_pass", pass1, 1);
    chk("rerun_err", ec1, 0);

    // default size, long clean run
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    tick(2002);
    chk("big_done_early", done2, 0);
    chk("big_busy", busy2, 1);
    tick(1);
    chk("big_done", done2, 1);
    chk("big_pass", pass2, 1);
    chk("big_err", ec2, 0);
    chk("big_first", fe2, 15'h7fff);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
